// File: rtl/gemm_fsm_nch.sv
// GEMM load sequencer: drains NUM_CH show-ahead request FIFOs into the systolic array row-load ports.
// Define GEMM_FSM_PERF_EN to add saturating job/busy/stall performance counters.
module gemm_fsm_nch #(
    parameter int NUM_CH  = 4,
    parameter int ROWS    = 4,
    parameter int ROW_W   = 64,
    localparam int ROW_S_W = $clog2(ROWS),
    localparam int CH_W    = $clog2(NUM_CH),
    localparam int ENTRY_W = 2*ROW_W+1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_CH*ENTRY_W-1:0] fifo_rdata,
    input  logic [NUM_CH-1:0]         fifo_empty,
    output logic [NUM_CH-1:0]         fifo_ren,
    input  logic                      drained,
    input  logic                      fifo_has_space,
    output logic [ROW_W-1:0]          weight_input_data,
    output logic [ROW_W-1:0]          partial_sum_data,
    output logic [ROW_S_W-1:0]        weight_input_row_sel,
    output logic [ROW_S_W-1:0]        partial_sum_row_sel,
    output logic                      weight_enable,
    output logic                      input_enable,
    output logic                      partial_enable,
    output logic [CH_W-1:0]           active_ch,
    output logic                      busy,
    output logic                      job_done,
    output logic                      proto_err,
    input  logic                      err_clr
`ifdef GEMM_FSM_PERF_EN
    ,
    output logic [31:0]               perf_jobs,
    output logic [31:0]               perf_busy_cyc,
    output logic [31:0]               perf_stall_cyc
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WLOAD, S_IPLOAD} state_t;

    state_t               r_state, w_state_nxt;
    logic [ROW_S_W-1:0]   r_cnt;
    logic [CH_W-1:0]      r_rr_ptr;
    logic [CH_W-1:0]      r_active_ch;
    logic [ROW_W-1:0]     r_wi_data, r_ps_data;
    logic [ROW_S_W-1:0]   r_wi_sel, r_ps_sel;
    logic                 r_wen, r_ien, r_busy, r_done, r_err;

    logic [ENTRY_W-1:0]   w_entry [NUM_CH];
    logic [ENTRY_W-1:0]   w_head;
    logic                 w_tag, w_emp, w_last;
    logic                 w_gnt_vld;
    logic [CH_W-1:0]      w_gnt_ch;
    logic                 w_pop, w_ok, w_mis;
    logic [NUM_CH-1:0]    w_ren;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_entry[g] = fifo_rdata[g*ENTRY_W +: ENTRY_W];
    end

    assign w_head = w_entry[r_active_ch];
    assign w_tag  = w_head[2*ROW_W];
    assign w_emp  = fifo_empty[r_active_ch];
    assign w_last = (r_cnt == ROW_S_W'(ROWS-1));

    // Scan farthest-first so the nearest non-empty channel after rr_ptr wins.
    always_comb begin
        logic [CH_W-1:0] c_idx;
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        c_idx     = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            c_idx = CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
            if (!fifo_empty[c_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = c_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_ok        = 1'b0;
        w_mis       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_vld)
                    w_state_nxt = w_entry[w_gnt_ch][2*ROW_W] ? S_WLOAD : S_IPLOAD;
            end
            S_WLOAD: begin
                w_pop = drained && !w_emp;
                if (w_pop) begin
                    if (w_tag) begin
                        w_ok = 1'b1;
                        if (w_last) w_state_nxt = S_IPLOAD;
                    end else begin
                        w_mis = 1'b1;
                    end
                end
            end
            S_IPLOAD: begin
                w_pop = fifo_has_space && !w_emp;
                if (w_pop) begin
                    if (!w_tag) begin
                        w_ok = 1'b1;
                        if (w_last) w_state_nxt = S_IDLE;
                    end else begin
                        w_mis = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ren = '0;
        if (w_pop) w_ren[r_active_ch] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rr_ptr    <= '0;
            r_active_ch <= '0;
            r_wi_data   <= '0;
            r_ps_data   <= '0;
            r_wi_sel    <= '0;
            r_ps_sel    <= '0;
            r_wen       <= 1'b0;
            r_ien       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_wen   <= 1'b0;
            r_ien   <= 1'b0;
            r_done  <= 1'b0;
            if (r_state == S_IDLE && w_gnt_vld)
                r_active_ch <= w_gnt_ch;
            if (w_ok) begin
                if (r_state == S_WLOAD) begin
                    r_wen     <= 1'b1;
                    r_wi_data <= w_head[ROW_W-1:0];
                    r_wi_sel  <= r_cnt;
                end else begin
                    r_ien     <= 1'b1;
                    r_wi_data <= w_head[2*ROW_W-1:ROW_W];
                    r_ps_data <= w_head[ROW_W-1:0];
                    r_wi_sel  <= r_cnt;
                    r_ps_sel  <= r_cnt;
                    r_done    <= w_last;
                    if (w_last) r_rr_ptr <= r_active_ch;
                end
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            // A mismatch in the same cycle as a clear keeps the flag set.
            if (w_mis)        r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

    assign fifo_ren             = w_ren;
    assign weight_input_data    = r_wi_data;
    assign partial_sum_data     = r_ps_data;
    assign weight_input_row_sel = r_wi_sel;
    assign partial_sum_row_sel  = r_ps_sel;
    assign weight_enable        = r_wen;
    assign input_enable         = r_ien;
    assign partial_enable       = r_ien;
    assign active_ch            = r_active_ch;
    assign busy                 = r_busy;
    assign job_done             = r_done;
    assign proto_err            = r_err;

`ifdef GEMM_FSM_PERF_EN
    logic [31:0] r_perf_jobs, r_perf_busy, r_perf_stall;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_perf_jobs  <= '0;
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_ok && r_state == S_IPLOAD && w_last)
                r_perf_jobs <= sat_inc(r_perf_jobs);
            if (r_state != S_IDLE)
                r_perf_busy <= sat_inc(r_perf_busy);
            // A mismatch always pops, so !w_pop already excludes it.
            if (r_state != S_IDLE && !w_pop)
                r_perf_stall <= sat_inc(r_perf_stall);
        end
    end

    assign perf_jobs      = r_perf_jobs;
    assign perf_busy_cyc  = r_perf_busy;
    assign perf_stall_cyc = r_perf_stall;
`endif

endmodule

// File: tb/tb_gemm_fsm_nch.sv
// Directed bench for gemm_fsm_nch: models four show-ahead FIFOs and checks each scenario inline.
module tb_gemm_fsm_nch;
    localparam int NCH = 4;
    localparam int RW  = 64;
    localparam int EW  = 2*RW+1;

    logic            CLK, RST;
    logic [NCH*EW-1:0] fifo_rdata;
    logic [NCH-1:0]  fifo_empty, fifo_ren;
    logic            drained, fifo_has_space, err_clr;
    logic [RW-1:0]   weight_input_data, partial_sum_data;
    logic [1:0]      weight_input_row_sel, partial_sum_row_sel, active_ch;
    logic            weight_enable, input_enable, partial_enable, busy, job_done, proto_err;
`ifdef GEMM_FSM_PERF_EN
    logic [31:0]     perf_jobs, perf_busy_cyc, perf_stall_cyc;
`endif

    gemm_fsm_nch #(.NUM_CH(NCH), .ROWS(4), .ROW_W(RW)) dut (
        .CLK(CLK), .RST(RST), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
        .drained(drained), .fifo_has_space(fifo_has_space),
        .weight_input_data(weight_input_data), .partial_sum_data(partial_sum_data),
        .weight_input_row_sel(weight_input_row_sel), .partial_sum_row_sel(partial_sum_row_sel),
        .weight_enable(weight_enable), .input_enable(input_enable), .partial_enable(partial_enable),
        .active_ch(active_ch), .busy(busy), .job_done(job_done), .proto_err(proto_err), .err_clr(err_clr)
`ifdef GEMM_FSM_PERF_EN
        , .perf_jobs(perf_jobs), .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    logic [EW-1:0] mem [NCH][64];
    int            wr_ptr [NCH];
    int            rd_ptr [NCH];
    logic          flush;
    int            ren_viol = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            fifo_empty[c]          = (rd_ptr[c] == wr_ptr[c]);
            fifo_rdata[c*EW +: EW] = mem[c][rd_ptr[c]];
        end
    end

    // FIFO pop side; flags pops from empty channels and multi-channel pops.
    always @(posedge CLK) begin
        if ($countones(fifo_ren) > 1) ren_viol = ren_viol + 1;
        for (int c = 0; c < NCH; c++) begin
            if (flush) rd_ptr[c] <= wr_ptr[c];
            else if (fifo_ren[c]) begin
                if (rd_ptr[c] == wr_ptr[c]) ren_viol = ren_viol + 1;
                else rd_ptr[c] <= rd_ptr[c] + 1;
            end
        end
    end

    function automatic logic [EW-1:0] ent(input logic tag, input logic [RW-1:0] in_r, input logic [RW-1:0] ps_r);
        return {tag, in_r, ps_r};
    endfunction

    task automatic push(input int ch, input logic [EW-1:0] e);
        mem[ch][wr_ptr[ch]] = e;
        wr_ptr[ch] = wr_ptr[ch] + 1;
    endtask

    task automatic test_reset;
        RST = 1'b1; flush = 1'b1; drained = 1'b1; fifo_has_space = 1'b1; err_clr = 1'b0;
        repeat (2) @(negedge CLK);
        n_chk++;
        if ({weight_enable, input_enable, partial_enable, busy, job_done, proto_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {weight_enable, input_enable, partial_enable, busy, job_done, proto_err});
        end
        n_chk++;
        if (active_ch !== 2'd0 || weight_input_data !== '0 || partial_sum_data !== '0 ||
            weight_input_row_sel !== 2'd0 || partial_sum_row_sel !== 2'd0 || fifo_ren !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_data ch=%0d wi=%h ps=%h ren=%b exp all zero",
                     active_ch, weight_input_data, partial_sum_data, fifo_ren);
        end
        RST = 1'b0; flush = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_weight_job;
        int wexp = 0, iexp = 0, first_w = -1, last_ip = -1, nbusy = 0, ndone = 0;
        for (int i = 0; i < 4; i++) push(0, ent(1'b1, '0, 64'hA0 + 64'(i)));
        for (int i = 0; i < 4; i++) push(0, ent(1'b0, 64'hB0 + 64'(i), 64'hC0 + 64'(i)));
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge CLK);
            if (busy) nbusy++;
            if (job_done) ndone++;
            if (weight_enable) begin
                n_chk++;
                if (weight_input_row_sel !== 2'(wexp) || weight_input_data !== 64'hA0 + 64'(wexp) || iexp != 0) begin
                    n_fail++;
                    $display("FAIL t1_wrow sel=%0d data=%h exp_sel=%0d exp_data=%h",
                             weight_input_row_sel, weight_input_data, wexp, 64'hA0 + 64'(wexp));
                end
                if (first_w < 0) first_w = cyc;
                wexp++;
            end
            if (input_enable) begin
                n_chk++;
                if (weight_input_data !== 64'hB0 + 64'(iexp) || partial_sum_data !== 64'hC0 + 64'(iexp) ||
                    weight_input_row_sel !== 2'(iexp) || partial_sum_row_sel !== 2'(iexp) ||
                    partial_enable !== 1'b1 || job_done !== (iexp == 3) || active_ch !== 2'd0) begin
                    n_fail++;
                    $display("FAIL t1_iprow in=%h ps=%h sel=%0d/%0d pe=%b done=%b ch=%0d exp_row=%0d",
                             weight_input_data, partial_sum_data, weight_input_row_sel,
                             partial_sum_row_sel, partial_enable, job_done, active_ch, iexp);
                end
                last_ip = cyc;
                iexp++;
            end
        end
        n_chk++;
        if (wexp != 4 || iexp != 4 || first_w != 2 || last_ip != 9) begin
            n_fail++;
            $display("FAIL t1_timing w=%0d ip=%0d first_w=%0d last_ip=%0d exp 4 4 2 9", wexp, iexp, first_w, last_ip);
        end
        n_chk++;
        if (nbusy != 8 || ndone != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_busy busy_cyc=%0d done=%0d busy_now=%b exp 8 1 0", nbusy, ndone, busy);
        end
    endtask

    task automatic test_round_robin;
        int n = 0, ndone = 0;
        for (int i = 0; i < 4; i++) push(1, ent(1'b0, 64'h10 + 64'(i), 64'h20 + 64'(i)));
        for (int i = 0; i < 4; i++) push(3, ent(1'b0, 64'h30 + 64'(i), 64'h40 + 64'(i)));
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge CLK);
            if (fifo_ren !== 4'd0) begin
                n_chk++;
                if (fifo_ren !== (4'd1 << active_ch)) begin
                    n_fail++;
                    $display("FAIL t2_ren ren=%b ch=%0d", fifo_ren, active_ch);
                end
            end
            if (job_done) ndone++;
            if (input_enable) begin
                int ech, r;
                ech = (n < 4) ? 1 : 3;
                r = n % 4;
                n_chk++;
                if (active_ch !== 2'(ech) || weight_input_data !== 64'(ech*16 + r) ||
                    partial_sum_data !== 64'(ech*16 + 16 + r) || weight_input_row_sel !== 2'(r) ||
                    job_done !== (r == 3)) begin
                    n_fail++;
                    $display("FAIL t2_row ch=%0d in=%h ps=%h sel=%0d done=%b exp_ch=%0d exp_row=%0d",
                             active_ch, weight_input_data, partial_sum_data, weight_input_row_sel, job_done, ech, r);
                end
                n++;
            end
        end
        n_chk++;
        if (n != 8 || ndone != 2) begin
            n_fail++;
            $display("FAIL t2_count rows=%0d done=%0d exp 8 2", n, ndone);
        end
    endtask

    task automatic test_drain_stall;
        int wexp = 0, iexp = 0, stall_left = 0, c_r1 = -1, c_r2 = -1;
`ifdef GEMM_FSM_PERF_EN
        logic [31:0] b_jobs, b_busy, b_stall;
        b_jobs = perf_jobs; b_busy = perf_busy_cyc; b_stall = perf_stall_cyc;
`endif
        for (int i = 0; i < 4; i++) push(2, ent(1'b1, '0, 64'hD0 + 64'(i)));
        for (int i = 0; i < 4; i++) push(2, ent(1'b0, 64'hE0 + 64'(i), 64'hF0 + 64'(i)));
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge CLK);
            if (stall_left > 0) begin
                n_chk++;
                if (weight_enable !== 1'b0 || fifo_ren !== 4'd0) begin
                    n_fail++;
                    $display("FAIL t3_stall we=%b ren=%b exp 0 0", weight_enable, fifo_ren);
                end
                stall_left--;
                if (stall_left == 0) drained = 1'b1;
            end
            if (weight_enable) begin
                n_chk++;
                if (weight_input_row_sel !== 2'(wexp) || weight_input_data !== 64'hD0 + 64'(wexp)) begin
                    n_fail++;
                    $display("FAIL t3_wrow sel=%0d data=%h exp_row=%0d", weight_input_row_sel, weight_input_data, wexp);
                end
                if (wexp == 1) begin
                    c_r1 = cyc;
                    drained = 1'b0;
                    stall_left = 3;
                end
                if (wexp == 2) c_r2 = cyc;
                wexp++;
            end
            if (input_enable) begin
                n_chk++;
                if (weight_input_data !== 64'hE0 + 64'(iexp) || partial_sum_data !== 64'hF0 + 64'(iexp)) begin
                    n_fail++;
                    $display("FAIL t3_iprow in=%h ps=%h exp_row=%0d", weight_input_data, partial_sum_data, iexp);
                end
                iexp++;
            end
        end
        n_chk++;
        if (wexp != 4 || iexp != 4 || c_r2 - c_r1 != 4) begin
            n_fail++;
            $display("FAIL t3_resume w=%0d ip=%0d gap=%0d exp 4 4 4", wexp, iexp, c_r2 - c_r1);
        end
`ifdef GEMM_FSM_PERF_EN
        n_chk++;
        if (perf_stall_cyc - b_stall !== 32'd3 || perf_busy_cyc - b_busy !== 32'd11 || perf_jobs - b_jobs !== 32'd1) begin
            n_fail++;
            $display("FAIL t3_perf stall=%0d busy=%0d jobs=%0d exp 3 11 1",
                     perf_stall_cyc - b_stall, perf_busy_cyc - b_busy, perf_jobs - b_jobs);
        end
`endif
    endtask

    task automatic test_proto_err;
        int wexp = 0, iexp = 0, first_w = -1, last_ip = -1, err_cyc = -1;
        n_chk++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_pre proto_err=%b exp 0", proto_err);
        end
        push(3, ent(1'b1, '0, 64'h50));
        push(3, ent(1'b0, 64'hBAD, 64'hBAD));
        for (int i = 1; i < 4; i++) push(3, ent(1'b1, '0, 64'h50 + 64'(i)));
        for (int i = 0; i < 4; i++) push(3, ent(1'b0, 64'h60 + 64'(i), 64'h70 + 64'(i)));
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge CLK);
            if (proto_err && err_cyc < 0) err_cyc = cyc;
            if (weight_enable) begin
                n_chk++;
                if (weight_input_row_sel !== 2'(wexp) || weight_input_data !== 64'h50 + 64'(wexp)) begin
                    n_fail++;
                    $display("FAIL t4_wrow sel=%0d data=%h exp_row=%0d", weight_input_row_sel, weight_input_data, wexp);
                end
                if (first_w < 0) first_w = cyc;
                wexp++;
            end
            if (input_enable) begin
                n_chk++;
                if (weight_input_data !== 64'h60 + 64'(iexp) || partial_sum_row_sel !== 2'(iexp)) begin
                    n_fail++;
                    $display("FAIL t4_iprow in=%h sel=%0d exp_row=%0d", weight_input_data, partial_sum_row_sel, iexp);
                end
                last_ip = cyc;
                iexp++;
            end
        end
        n_chk++;
        if (wexp != 4 || iexp != 4 || first_w != 2 || err_cyc != 3 || last_ip != 10 || proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_drop w=%0d ip=%0d first_w=%0d err_cyc=%0d last_ip=%0d err=%b exp 4 4 2 3 10 1",
                     wexp, iexp, first_w, err_cyc, last_ip, proto_err);
        end
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        n_chk++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_clr proto_err=%b exp 0", proto_err);
        end
    endtask

    task automatic test_reset_mid;
        logic hit = 1'b0;
        int n = 0;
        for (int i = 0; i < 4; i++) push(2, ent(1'b0, 64'h80 + 64'(i), 64'h90 + 64'(i)));
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge CLK);
            if (!hit && input_enable && weight_input_row_sel == 2'd2) begin
                hit = 1'b1;
                #1 RST = 1'b1; flush = 1'b1;
                #1;
                n_chk++;
                if ({weight_enable, input_enable, partial_enable, busy, job_done, proto_err} !== 6'b0 ||
                    active_ch !== 2'd0 || weight_input_data !== '0 || partial_sum_data !== '0 ||
                    weight_input_row_sel !== 2'd0 || fifo_ren !== 4'd0) begin
                    n_fail++;
                    $display("FAIL t5_async en=%b%b busy=%b ch=%0d wi=%h ren=%b exp all zero",
                             weight_enable, input_enable, busy, active_ch, weight_input_data, fifo_ren);
                end
            end
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL t5_hit row 2 never reached");
        end
        @(negedge CLK);
        RST = 1'b0; flush = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge CLK);
            n_chk++;
            if (fifo_ren !== 4'd0 || busy !== 1'b0 || active_ch !== 2'd0) begin
                n_fail++;
                $display("FAIL t5_idle ren=%b busy=%b ch=%0d exp 0 0 0", fifo_ren, busy, active_ch);
            end
        end
        for (int i = 0; i < 4; i++) push(0, ent(1'b0, 64'h100 + 64'(i), 64'h0));
        for (int i = 0; i < 4; i++) push(1, ent(1'b0, 64'h110 + 64'(i), 64'h0));
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge CLK);
            if (input_enable) begin
                int ech;
                ech = (n < 4) ? 1 : 0;
                n_chk++;
                if (active_ch !== 2'(ech) || weight_input_data !== 64'h100 + 64'(ech*16 + n % 4)) begin
                    n_fail++;
                    $display("FAIL t5_rr ch=%0d in=%h exp_ch=%0d", active_ch, weight_input_data, ech);
                end
                n++;
            end
        end
        n_chk++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL t5_count rows=%0d exp 8", n);
        end
    endtask

    task automatic test_space_toggle;
        int iexp = 0;
        logic prev_sp = 1'b1;
        for (int i = 0; i < 4; i++) push(1, ent(1'b0, 64'hA8 + 64'(i), 64'hC8 + 64'(i)));
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge CLK);
            if (input_enable) begin
                n_chk++;
                if (prev_sp !== 1'b1 || weight_input_data !== 64'hA8 + 64'(iexp) ||
                    partial_sum_data !== 64'hC8 + 64'(iexp) || weight_input_row_sel !== 2'(iexp)) begin
                    n_fail++;
                    $display("FAIL t6_row sp=%b in=%h ps=%h sel=%0d exp_row=%0d",
                             prev_sp, weight_input_data, partial_sum_data, weight_input_row_sel, iexp);
                end
                iexp++;
            end
            fifo_has_space = cyc[0];
            prev_sp = fifo_has_space;
            #1;
            n_chk++;
            if (fifo_ren !== 4'd0 && !fifo_has_space) begin
                n_fail++;
                $display("FAIL t6_ren ren=%b space=%b", fifo_ren, fifo_has_space);
            end
        end
        fifo_has_space = 1'b1;
        n_chk++;
        if (iexp != 4 || ren_viol != 0) begin
            n_fail++;
            $display("FAIL t6_count rows=%0d ren_viol=%0d exp 4 0", iexp, ren_viol);
        end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) wr_ptr[c] = 0;
        RST = 1'b1; flush = 1'b1; drained = 1'b1; fifo_has_space = 1'b1; err_clr = 1'b0;
        test_reset;
        test_weight_job;
        test_round_robin;
        test_drain_stall;
        test_proto_err;
        test_reset_mid;
        test_space_toggle;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
